// File: rtl/seven_seg_scan_if.sv
// Bundle between the seven-segment PIO/control side and the scanner.
// The master drives the digit value and control bits. The slave, which is
// the scanner, drives the segment and digit lines and the frame pulse.
interface seven_seg_scan_if;
  logic [7:0] value_in;
  logic       enable;
  logic       lz_en;
  logic [6:0] seg_n;
  logic [1:0] dig_n;
  logic       frame_pulse;

  modport master (
    output value_in,
    output enable,
    output lz_en,
    input  seg_n,
    input  dig_n,
    input  frame_pulse
  );

  modport slave (
    input  value_in,
    input  enable,
    input  lz_en,
    output seg_n,
    output dig_n,
    output frame_pulse
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Two-digit multiplexed seven-segment scanner.
// Each frame runs BLANK0 -> SHOW0 -> BLANK1 -> SHOW1. The dark gaps keep
// ghosting off the display. The digit value is captured into a shadow
// register once per frame, so the two digits of a frame always match.
module seven_seg_scan #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input logic             clk,
  input logic             reset_n,
  seven_seg_scan_if.slave io_disp
);

  localparam int MAX_D = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] DIG_OFF = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic [7:0]       r_shadow;
  logic [7:0]       w_shadowNext;
  logic [6:0]       r_segN;
  logic [6:0]       w_segNNext;
  logic [1:0]       r_digN;
  logic [1:0]       w_digNNext;
  logic             w_lastCount;
  logic             w_load;
  logic             w_suppressHigh;

  // Hex nibble to active-high gfedcba segment pattern.
  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Applies the board polarity to an active-high segment pattern.
  function automatic logic [6:0] segPolar(input logic [6:0] seg);
    return (ACTIVE_LOW != 0) ? ~seg : seg;
  endfunction

  // Applies the board polarity to an active-high digit select.
  function automatic logic [1:0] digPolar(input logic [1:0] dig);
    return (ACTIVE_LOW != 0) ? ~dig : dig;
  endfunction

  // Detects the last cycle of the current state and the shadow-load cycle.
  always_comb begin
    w_lastCount = 1'b0;
    w_load      = 1'b0;
    if ((r_state == BLANK0) || (r_state == BLANK1)) begin
      w_lastCount = (r_count == BLANK_LAST);
    end else begin
      w_lastCount = (r_count == SHOW_LAST);
    end
    w_load       = io_disp.enable && (r_state == BLANK0) && (r_count == '0);
    w_shadowNext = w_load ? io_disp.value_in : r_shadow;
  end

  // Leading-zero suppression is decided once, when SHOW1 is entered.
  always_comb begin
    w_suppressHigh = io_disp.lz_en && (r_shadow[7:4] == 4'h0);
  end

  // Next state, duration counter and the output pattern for the next state.
  // The outputs load only on a state entry, so they stay fixed for the whole
  // state.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count + 1'b1;
    w_segNNext  = r_segN;
    w_digNNext  = r_digN;
    if (!io_disp.enable) begin
      w_stateNext = BLANK0;
      w_countNext = '0;
      w_segNNext  = SEG_OFF;
      w_digNNext  = DIG_OFF;
    end else if (w_lastCount) begin
      w_countNext = '0;
      case (r_state)
        BLANK0: begin
          w_stateNext = SHOW0;
          w_segNNext  = segPolar(hexDecode(w_shadowNext[3:0]));
          w_digNNext  = digPolar(2'b01);
        end
        SHOW0: begin
          w_stateNext = BLANK1;
          w_segNNext  = SEG_OFF;
          w_digNNext  = DIG_OFF;
        end
        BLANK1: begin
          w_stateNext = SHOW1;
          if (w_suppressHigh) begin
            w_segNNext = SEG_OFF;
            w_digNNext = DIG_OFF;
          end else begin
            w_segNNext = segPolar(hexDecode(r_shadow[7:4]));
            w_digNNext = digPolar(2'b10);
          end
        end
        default: begin
          w_stateNext = BLANK0;
          w_segNNext  = SEG_OFF;
          w_digNNext  = DIG_OFF;
        end
      endcase
    end
  end

  // State, counter, shadow and output registers with asynchronous reset to dark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= BLANK0;
      r_count  <= '0;
      r_shadow <= 8'h00;
      r_segN   <= SEG_OFF;
      r_digN   <= DIG_OFF;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_shadow <= w_shadowNext;
      r_segN   <= w_segNNext;
      r_digN   <= w_digNNext;
    end
  end

  assign io_disp.seg_n       = r_segN;
  assign io_disp.dig_n       = r_digN;
  assign io_disp.frame_pulse = reset_n & w_load;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed scoreboard bench for seven_seg_scan.
// Each stimulus step pushes the expected per-cycle outputs, and checkOutput
// pops and compares them once per cycle, sampled on the falling clock edge.
module tb_seven_seg_scan;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan_if ifLow ();
  seven_seg_scan_if ifHigh ();

  seven_seg_scan #(.CLK_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1)) dutLow (
    .clk     (clk),
    .reset_n (reset_n),
    .io_disp (ifLow)
  );

  seven_seg_scan #(.CLK_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(0)) dutHigh (
    .clk     (clk),
    .reset_n (reset_n),
    .io_disp (ifHigh)
  );

  typedef struct {
    logic [1:0] dig;
    logic [6:0] seg;
    logic       fp;
    bit         sel;
    string      tag;
  } exp_t;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mkExp(input bit al, input logic [1:0] digHi,
                                 input logic [6:0] segHi, input bit fp,
                                 input bit sel, input string tag);
    exp_t e;
    e.dig = al ? ~digHi : digHi;
    e.seg = al ? ~segHi : segHi;
    e.fp  = fp;
    e.sel = sel;
    e.tag = tag;
    return e;
  endfunction

  task automatic pushFrame(input logic [7:0] v, input bit lz, input bit sel,
                           input int first, input int last, input string tag);
    bit al;
    al = (sel == 1'b0);
    for (int c = first; c <= last; c++) begin
      if (c < 2)
        sbQ.push_back(mkExp(al, 2'b00, 7'h00, (c == 0), sel, $sformatf("%s.c%0d.blank0", tag, c)));
      else if (c < 6)
        sbQ.push_back(mkExp(al, 2'b01, HEX_TBL[v[3:0]], 1'b0, sel, $sformatf("%s.c%0d.show0", tag, c)));
      else if (c < 8)
        sbQ.push_back(mkExp(al, 2'b00, 7'h00, 1'b0, sel, $sformatf("%s.c%0d.blank1", tag, c)));
      else if (lz && (v[7:4] == 4'h0))
        sbQ.push_back(mkExp(al, 2'b00, 7'h00, 1'b0, sel, $sformatf("%s.c%0d.show1lz", tag, c)));
      else
        sbQ.push_back(mkExp(al, 2'b10, HEX_TBL[v[7:4]], 1'b0, sel, $sformatf("%s.c%0d.show1", tag, c)));
    end
  endtask

  task automatic pushDark(input int n, input bit sel, input string tag);
    for (int c = 0; c < n; c++)
      sbQ.push_back(mkExp(sel == 1'b0, 2'b00, 7'h00, 1'b0, sel, $sformatf("%s.%0d", tag, c)));
  endtask

  task automatic applyStimulus(input bit sel, input logic [7:0] v, input bit en, input bit lz);
    if (sel) begin
      ifHigh.value_in = v;
      ifHigh.enable   = en;
      ifHigh.lz_en    = lz;
    end else begin
      ifLow.value_in = v;
      ifLow.enable   = en;
      ifLow.lz_en    = lz;
    end
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [1:0] obsDig;
    logic [6:0] obsSeg;
    logic       obsFp;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=empty expected=entry");
      return;
    end
    e      = sbQ.pop_front();
    obsDig = e.sel ? ifHigh.dig_n : ifLow.dig_n;
    obsSeg = e.sel ? ifHigh.seg_n : ifLow.seg_n;
    obsFp  = e.sel ? ifHigh.frame_pulse : ifLow.frame_pulse;
    checks++;
    assert (obsDig === e.dig) else begin
      errors++;
      $error("FAIL %s.dig observed=%b expected=%b", e.tag, obsDig, e.dig);
    end
    checks++;
    assert (obsSeg === e.seg) else begin
      errors++;
      $error("FAIL %s.seg observed=%h expected=%h", e.tag, obsSeg, e.seg);
    end
    checks++;
    assert (obsFp === e.fp) else begin
      errors++;
      $error("FAIL %s.fp observed=%b expected=%b", e.tag, obsFp, e.fp);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      #1;
      checkOutput();
      @(negedge clk);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b0;

    @(negedge clk);
    $display("[TB] reset state");
    pushDark(1, 1'b0, "reset");
    pushDark(1, 1'b1, "resetHigh");
    #1;
    checkOutput();
    checkOutput();

    @(negedge clk);
    applyStimulus(1'b0, 8'h3A, 1'b1, 1'b0);
    pushDark(3, 1'b0, "resetHold");
    runCycles(3);

    $display("[TB] frame 3A with mid-frame value change");
    reset_n = 1'b1;
    pushFrame(8'h3A, 1'b0, 1'b0, 0, 2, "f3A");
    runCycles(3);
    applyStimulus(1'b0, 8'h55, 1'b1, 1'b0);
    pushFrame(8'h3A, 1'b0, 1'b0, 3, 11, "f3A");
    runCycles(9);
    pushFrame(8'h55, 1'b0, 1'b0, 0, 11, "f55");
    runCycles(12);

    $display("[TB] leading zero suppression");
    applyStimulus(1'b0, 8'h07, 1'b1, 1'b1);
    pushFrame(8'h07, 1'b1, 1'b0, 0, 9, "f07lz");
    runCycles(10);
    applyStimulus(1'b0, 8'h07, 1'b1, 1'b0);
    pushFrame(8'h07, 1'b1, 1'b0, 10, 11, "f07lz");
    runCycles(2);
    pushFrame(8'h07, 1'b0, 1'b0, 0, 11, "f07");
    runCycles(12);

    $display("[TB] hex sweep");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = {4'(2 * i + 1), 4'(2 * i)};
      applyStimulus(1'b0, v, 1'b1, 1'b0);
      pushFrame(v, 1'b0, 1'b0, 0, 11, $sformatf("sweep%02h", v));
      runCycles(12);
    end

    $display("[TB] enable dropped in SHOW1");
    applyStimulus(1'b0, 8'h3A, 1'b1, 1'b0);
    pushFrame(8'h3A, 1'b0, 1'b0, 0, 9, "fDrop");
    runCycles(9);
    applyStimulus(1'b0, 8'hC4, 1'b0, 1'b0);
    runCycles(1);
    pushDark(3, 1'b0, "disabled");
    runCycles(3);
    applyStimulus(1'b0, 8'hC4, 1'b1, 1'b0);
    pushFrame(8'hC4, 1'b0, 1'b0, 0, 11, "fResume");
    runCycles(12);

    $display("[TB] async reset in SHOW0");
    applyStimulus(1'b0, 8'h3A, 1'b1, 1'b0);
    pushFrame(8'h3A, 1'b0, 1'b0, 0, 3, "fPreReset");
    runCycles(4);
    reset_n = 1'b0;
    pushDark(1, 1'b0, "asyncReset");
    #1;
    checkOutput();
    @(negedge clk);
    reset_n = 1'b1;
    pushFrame(8'h3A, 1'b0, 1'b0, 0, 11, "fPostReset");
    runCycles(12);

    $display("[TB] active-high instance");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b1, 1'b0);
    pushFrame(8'h08, 1'b0, 1'b1, 0, 11, "hi08");
    runCycles(12);
    applyStimulus(1'b1, 8'h05, 1'b1, 1'b1);
    pushFrame(8'h05, 1'b1, 1'b1, 0, 11, "hi05lz");
    runCycles(12);

    checks++;
    assert (sbQ.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, clk cycles each digit is lit per frame (legal >= 2).
REQ-002 Parameter BLANK_CYCLES, default 500, clk cycles all digits are dark before each digit (legal >= 1).
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = segment/digit outputs active-low, 0 = active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 value_in  input  8  two hex digits from the seven-segment PIO out_port; [3:0] = digit0, [7:4] = digit1.
REQ-007 enable  input  1  1 = scanning active, 0 = display dark and FSM parked.
REQ-008 lz_en  input  1  1 = suppress digit1 when its nibble is 0.
REQ-009 seg_n  output  7  segment drive, bit0 = a through bit6 = g, polarity per ACTIVE_LOW.
REQ-010 dig_n  output  2  digit select, bit0 = digit0, bit1 = digit1, polarity per ACTIVE_LOW.
REQ-011 frame_pulse  output  1  high for exactly the cycle in which value_in is sampled into the shadow register.

Function
REQ-012 FSM states BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0, cyclic, no other transitions while enable = 1.
REQ-013 A duration counter counts 0..D-1 in each state; D = BLANK_CYCLES in BLANK0/BLANK1, D = CLK_DIV in SHOW0/SHOW1; on count D-1 the next edge moves to the next state and clears the counter.
REQ-014 Frame period is 2*(CLK_DIV + BLANK_CYCLES) cycles exactly.
REQ-015 Counter width is sized for max(CLK_DIV, BLANK_CYCLES) - 1; no wrap other than the REQ-013 clear.
REQ-016 Shadow register (8 bits) loads value_in on the edge ending a cycle with state = BLANK0, count = 0, and enable = 1; at no other time.
REQ-017 frame_pulse = 1 exactly in that cycle (state = BLANK0, count = 0, enable = 1), else 0.
REQ-018 Displayed digits come only from the shadow register; value_in changes mid-frame do not affect the current frame.
REQ-019 Hex decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 seg_n and dig_n are registered and change on the same edge the FSM enters a state.
REQ-021 In BLANK0/BLANK1 both digits are off and all segments are off.
REQ-022 In SHOW0 only digit0 is on, with segments = decode(shadow[3:0]).
REQ-023 In SHOW1 only digit1 is on, with segments = decode(shadow[7:4]); if lz_en = 1 and shadow[7:4] = 0, digit1 and all segments are off for the whole SHOW1 state.
REQ-024 ACTIVE_LOW = 1 inverts the active-high segment and digit values; ACTIVE_LOW = 0 passes them through unchanged.
REQ-025 enable = 0 sampled on an edge forces state = BLANK0, count = 0, all outputs off, and shadow held.
REQ-026 When enable returns to 1, the first cycle is the frame_pulse/load cycle, followed by a normal frame.
REQ-027 At no time is more than one digit on, including across state transitions and enable changes.

Reset
REQ-028 reset_n = 0 immediately, without clk, sets state BLANK0, count 0, shadow 8'h00, both digits off, all segments off, frame_pulse 0.
REQ-029 Reset asserted mid-operation abandons the current frame; after release, operation resumes per REQ-026 if enable = 1.

Verification (CLK_DIV=4, BLANK_CYCLES=2, ACTIVE_LOW=1 unless stated)
REQ-030 Reset, then hold: dig_n = 2'b11, seg_n = 7'h7F, frame_pulse = 0.
REQ-031 value_in = 8'h3A, enable = 1, lz_en = 0: frame_pulse at cycle 0; then cycles 2-5 dig_n = 2'b10, seg_n = 7'h08; cycles 6-7 dark; cycles 8-11 dig_n = 2'b01, seg_n = 7'h30; period 12.
REQ-032 value_in changes to 8'h55 during SHOW0: the current frame still shows A/3; the next frame shows seg_n = 7'h12 on both digits.
REQ-033 value_in = 8'h07, lz_en = 1: SHOW0 seg_n = 7'h78; SHOW1 dig_n = 2'b11, seg_n = 7'h7F. With lz_en = 0, SHOW1 seg_n = 7'h40.
REQ-034 enable dropped mid-SHOW1: the next edge gives dig_n = 2'b11, seg_n = 7'h7F; on re-enable, frame_pulse in the first cycle and the 12-cycle frame resumes. Async reset mid-SHOW0 gives dark outputs with no clk edge.
REQ-035 ACTIVE_LOW = 0, value_in = 8'h08: SHOW0 dig_n = 2'b01, seg_n = 7'h7F; blank states give dig_n = 2'b00, seg_n = 7'h00.
